// File: rtl/dmem_store_buf_if.sv
// Load/store bus between the processor port and the data-memory stage.
interface dmem_store_buf_if;
  logic [31:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall;

  modport master (
    output addr, wr_en, rd_en, wdata, wmask,
    input  rdata, rvalid, stall
  );

  modport slave (
    input  addr, wr_en, rd_en, wdata, wmask,
    output rdata, rvalid, stall
  );
endinterface

// File: rtl/dmem_store_buf.sv
// Data-memory stage: single-port 64-bit line array behind a small FIFO store buffer.
// Stores retire into the buffer; loads stall on line hazards until the hit entries drain.
module dmem_store_buf #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  dmem_store_buf_if.slave             bus,
  input  logic                        flush,
  output logic                        flush_done,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] line;
    logic [63:0]       data;
    logic [7:0]        mask;
  } sb_entry_t;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

  logic [63:0]       mem_q [DEPTH];
  sb_entry_t         sb_q  [SB_DEPTH];
  sb_entry_t         head_e;
  logic [PTR_W-1:0]  head_q, tail_q, off;
  logic [CNT_W-1:0]  count_q;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_line;
  logic              hit_c, full_c, stall_c, st_acc_c, ld_acc_c, drain_c;
  logic              unused_addr_bits;

  assign req_line         = bus.addr[ADDR_W+2:3];
  assign unused_addr_bits = ^{bus.addr[31:ADDR_W+3], bus.addr[1:0]};
  assign head_e           = sb_q[head_q];
  assign full_c           = (count_q == CNT_W'(SB_DEPTH));

  // Line-hazard lookup over the occupied slots only; byte mask is deliberately ignored.
  always_comb begin
    hit_c = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if ((CNT_W'(off) < count_q) && (sb_q[i].line == req_line)) hit_c = 1'b1;
    end
  end

  assign stall_c  = ((state_q != ST_RUN) && (bus.wr_en || bus.rd_en))
                  || (bus.wr_en && full_c)
                  || (bus.rd_en && hit_c);
  assign st_acc_c = bus.wr_en && !stall_c;
  assign ld_acc_c = bus.rd_en && !bus.wr_en && !stall_c;
  // The array is single-ported: drain only in cycles where no request uses it.
  assign drain_c  = !rst && (count_q != '0) && !(st_acc_c || ld_acc_c);
  assign bus.stall = stall_c;
  assign sb_count  = count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: if ((count_q == '0) || ((count_q == CNT_W'(1)) && drain_c)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_done <= (state_d == ST_DONE);
      bus.rvalid <= ld_acc_c;
      if (ld_acc_c) bus.rdata <= bus.addr[2] ? mem_q[req_line][63:32] : mem_q[req_line][31:0];
      if (st_acc_c) tail_q <= tail_q + PTR_W'(1);
      if (drain_c)  head_q <= head_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(st_acc_c) - CNT_W'(drain_c);
    end
  end

  always_ff @(posedge clk) begin
    if (st_acc_c) sb_q[tail_q] <= '{line: req_line, data: bus.wdata, mask: bus.wmask};
  end

  // Masked byte write of the oldest buffered store.
  always_ff @(posedge clk) begin
    if (drain_c) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (head_e.mask[b]) mem_q[head_e.line][8*b +: 8] <= head_e.data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buf.sv
// Directed and random checks of dmem_store_buf against a queue/associative-array memory model.
module tb_dmem_store_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       flush_done;
  logic [2:0] sb_count;

  dmem_store_buf_if bus ();

  dmem_store_buf #(.ADDR_W(10), .SB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .flush_done(flush_done), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned line;
    logic [63:0] data;
    logic [7:0]  mask;
  } st_t;

  st_t               sbq[$];
  logic [63:0]       mem_m [int unsigned];
  int                mode;          // 0 running, 1 flushing, 2 flush complete
  logic              e_rv, e_fd;
  logic [31:0]       e_rdata;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model decides stall/accept/drain from the rules.
  task automatic step(input logic r, input logic [31:0] a, input logic we, input logic re,
                      input logic [63:0] wd, input logic [7:0] wm, input logic fl,
                      output logic stalled);
    int unsigned line;
    logic hit, e_stall, acc_st, acc_ld;
    st_t h;
    @(negedge clk);
    rst = r; bus.addr = a; bus.wr_en = we; bus.rd_en = re;
    bus.wdata = wd; bus.wmask = wm; flush = fl;
    #1;
    line = (a >> 3) & 32'h3FF;
    hit = 1'b0;
    foreach (sbq[i]) if (sbq[i].line == line) hit = 1'b1;
    e_stall = ((mode != 0) && (we || re)) || (we && sbq.size() == 4) || (re && hit);
    stalled = e_stall;
    if (!r) check("stall", 64'(bus.stall), 64'(e_stall));
    if (r) begin
      sbq.delete();
      mode = 0; e_rv = 1'b0; e_fd = 1'b0; e_rdata = '0;
    end else begin
      acc_st = we && !e_stall;
      acc_ld = re && !we && !e_stall;
      e_rv = acc_ld;
      if (acc_ld) e_rdata = a[2] ? mem_m[line][63:32] : mem_m[line][31:0];
      if (!acc_st && !acc_ld && sbq.size() > 0) begin
        h = sbq.pop_front();
        for (int b = 0; b < 8; b++)
          if (h.mask[b]) mem_m[h.line][8*b +: 8] = h.data[8*b +: 8];
      end
      if (acc_st) sbq.push_back('{line, wd, wm});
      case (mode)
        0: if (fl) mode = 1;
        1: if (sbq.size() == 0) mode = 2;
        default: mode = 0;
      endcase
      e_fd = (mode == 2);
    end
    @(posedge clk);
    #1;
    check("rvalid", 64'(bus.rvalid), 64'(e_rv));
    if (e_rv || r) check("rdata", 64'(bus.rdata), 64'(e_rdata));
    check("sb_count", 64'(sb_count), 64'(sbq.size()));
    check("flush_done", 64'(flush_done), 64'(e_fd));
    rst = 1'b0; flush = 1'b0;
  endtask

  // Holds a request stable until the model says it is accepted, with a cycle budget.
  task automatic req(input logic [31:0] a, input logic we, input logic re,
                     input logic [63:0] wd, input logic [7:0] wm);
    logic s;
    for (int t = 0; t < 20; t++) begin
      step(1'b0, a, we, re, wd, wm, 1'b0, s);
      if (!s) return;
    end
    n_cmp++; n_err++;
    $display("FAIL req_timeout: request at %0h not accepted within 20 cycles", a);
  endtask

  task automatic idle(input int n);
    logic s;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 8'h0, 1'b0, s);
  endtask

  task automatic do_rst();
    logic s;
    step(1'b1, 32'h0, 1'b0, 1'b0, 64'h0, 8'h0, 1'b0, s);
  endtask

  initial begin
    logic s;
    int   op;
    int unsigned ln;
    logic [31:0] a;
    mode = 0; e_rv = 0; e_fd = 0; e_rdata = '0;
    bus.addr = '0; bus.wr_en = 0; bus.rd_en = 0; bus.wdata = '0; bus.wmask = '0;

    // Reset state, then give lines 0..15 known contents.
    do_rst();
    check("rst_sb_count", 64'(sb_count), 64'h0);
    for (int i = 0; i < 16; i++) req(32'(i * 8), 1'b1, 1'b0, {$urandom(), $urandom()}, 8'hFF);
    step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 8'h0, 1'b1, s);
    idle(8);

    // Full store then word loads.
    do_rst();
    req(32'h10, 1'b1, 1'b0, 64'h1122334455667788, 8'hFF);
    idle(1);
    req(32'h10, 1'b0, 1'b1, 64'h0, 8'h0);
    check("t1_lo", 64'(bus.rdata), 64'h55667788);
    req(32'h14, 1'b0, 1'b1, 64'h0, 8'h0);
    check("t1_hi", 64'(bus.rdata), 64'h11223344);

    // Single-byte merge.
    req(32'h10, 1'b1, 1'b0, 64'hAA, 8'h01);
    idle(1);
    req(32'h10, 1'b0, 1'b1, 64'h0, 8'h0);
    check("t2_merge", 64'(bus.rdata), 64'h556677AA);

    // Load hazard on a freshly buffered line.
    req(32'h20, 1'b1, 1'b0, 64'h0000000500000007, 8'hFF);
    req(32'h24, 1'b0, 1'b1, 64'h0, 8'h0);
    check("t3_hazard", 64'(bus.rdata), 64'h5);

    // Fill the buffer back-to-back; fifth store waits one cycle.
    do_rst();
    for (int i = 0; i < 4; i++) begin
      req(32'(i * 8), 1'b1, 1'b0, 64'(i + 100), 8'hFF);
      check("t4_fill", 64'(sb_count), 64'(i + 1));
    end
    step(1'b0, 32'h20, 1'b1, 1'b0, 64'h104, 8'hFF, 1'b0, s);
    check("t4_full_drain", 64'(sb_count), 64'h3);
    req(32'h20, 1'b1, 1'b0, 64'h104, 8'hFF);
    check("t4_accept", 64'(sb_count), 64'h4);
    idle(6);

    // Flush with three buffered stores; requests stall until the drain completes.
    for (int i = 0; i < 3; i++) req(32'(8 * (i + 8)), 1'b1, 1'b0, {$urandom(), $urandom()}, 8'h0F);
    step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 8'h0, 1'b1, s);
    req(32'h40, 1'b0, 1'b1, 64'h0, 8'h0);
    check("t5_after_flush", 64'(sb_count), 64'h0);

    // Reset in the middle of a flush discards the remaining stores.
    for (int i = 0; i < 3; i++) req(32'(8 * (i + 5)), 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0000 + 64'(i), 8'hFF);
    step(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 8'h0, 1'b1, s);
    check("t6_mid_flush", 64'(sb_count), 64'h2);
    do_rst();
    check("t6_cleared", 64'(sb_count), 64'h0);
    req(32'h30, 1'b0, 1'b1, 64'h0, 8'h0);
    req(32'h38, 1'b0, 1'b1, 64'h0, 8'h0);

    // Random traffic over lines 0..15 with random ignored address bits.
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 99));
      ln = $urandom_range(0, 15);
      a  = ($urandom() & 32'hFFFF_E007) | (ln << 3);
      if (op < 40)      req(a, 1'b1, 1'b0, {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
      else if (op < 72) req(a, 1'b0, 1'b1, 64'h0, 8'h0);
      else if (op < 77) req(a, 1'b1, 1'b1, {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
      else if (op < 83) step(1'b0, a, 1'b0, 1'b0, 64'h0, 8'h0, 1'b1, s);
      else if (op < 85) do_rst();
      else              idle(1);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
